// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with single-cycle ops and an iterative shift-add multiplier.
// Results are registered and held until the consumer takes them.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [OPW-1:0]   OP,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic             Over,
    output logic             Zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(1);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(7);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(8);
    localparam logic [OPW-1:0] OP_ROTL = OPW'(9);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(10);

    typedef enum logic [1:0] {IDLE, MULT, FULL} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   out_q, mplier_q;
    logic               over_q, zero_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
    logic [CW-1:0]      cnt_q, rot_amt;
    logic               accept, is_mul;
    logic [WIDTH:0]     res_d, shl, shr;

    assign InReady  = state_q == IDLE || (state_q == FULL && OutReady);
    assign OutValid = state_q == FULL;
    assign Out      = out_q;
    assign Over     = over_q;
    assign Zero     = zero_q;
    assign accept   = InValid && InReady;
    assign is_mul   = OP == OP_MUL;
    assign rot_amt  = InputB[CW-1:0];
    assign shl      = {1'b0, InputA} << InputB;
    assign shr      = {InputA, 1'b0} >> InputB;
    assign acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;

    // res_d is {flag, result}; unlisted opcodes fall back to ADD
    always_comb begin
        res_d = {1'b0, InputA} + {1'b0, InputB};
        case (OP)
            OP_SHL:  res_d = shl;
            OP_SHR:  res_d = {shr[0], shr[WIDTH:1]};
            OP_AND:  res_d = {1'b0, InputA & InputB};
            OP_OR:   res_d = {1'b0, InputA | InputB};
            OP_XOR:  res_d = {1'b0, InputA ^ InputB};
            OP_SLT:  res_d = (WIDTH+1)'(InputA < InputB);
            OP_MOV:  res_d = {1'b0, InputB};
            OP_SUB:  res_d = {InputA < InputB, InputA - InputB};
            OP_ROTL: res_d = {1'b0, (InputA << rot_amt) | (InputA >> (WIDTH - int'(rot_amt)))};
            default: res_d = {1'b0, InputA} + {1'b0, InputB};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            out_q    <= '0;
            over_q   <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                MULT: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FULL;
                        out_q   <= acc_d[WIDTH-1:0];
                        over_q  <= |acc_d[2*WIDTH-1:WIDTH];
                        zero_q  <= acc_d[WIDTH-1:0] == '0;
                    end
                end
                default: begin
                    if (accept && is_mul) begin
                        state_q  <= MULT;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, InputA};
                        mplier_q <= InputB;
                        cnt_q    <= '0;
                    end else if (accept) begin
                        state_q <= FULL;
                        out_q   <= res_d[WIDTH-1:0];
                        over_q  <= res_d[WIDTH];
                        zero_q  <= res_d[WIDTH-1:0] == '0;
                    end else if (state_q == FULL && OutReady) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors plus a cycle-level reference model checked every cycle.
module tb_alu_pipe;
    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       InValid = 1'b0;
    logic       OutReady = 1'b1;
    logic [7:0] InputA = '0;
    logic [7:0] InputB = '0;
    logic [3:0] OP = '0;
    logic       InReady, OutValid, Over, Zero;
    logic [7:0] Out;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    alu_pipe #(.WIDTH(8), .OPW(4)) dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .InputA(InputA), .InputB(InputB), .OP(OP), .OutValid(OutValid),
        .OutReady(OutReady), .Out(Out), .Over(Over), .Zero(Zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, x, r;
        ai = a;
        bi = b;
        case (op)
            4'd1: x = (bi > 8) ? 0 : (ai << bi);
            4'd2: x = (bi == 0) ? ai : (bi > 8) ? 0 : ((ai >> bi) | (((ai >> (bi - 1)) & 1) << 8));
            4'd3: x = ai & bi;
            4'd4: x = ai | bi;
            4'd5: x = ai ^ bi;
            4'd6: x = (ai < bi) ? 1 : 0;
            4'd7: x = bi;
            4'd8: x = ((ai - bi) & 255) | ((ai < bi) ? 256 : 0);
            4'd9: begin
                r = bi % 8;
                x = ((ai << r) | (ai >> (8 - r))) & 255;
            end
            4'd10: begin
                x = ai * bi;
                x = (x & 255) | ((x > 255) ? 256 : 0);
            end
            default: x = ai + bi;
        endcase
        return x[8:0];
    endfunction

    logic       m_valid = 1'b0, m_over = 1'b0, m_zero = 1'b0, m_started = 1'b0;
    logic [7:0] m_out = '0;
    logic [8:0] m_pend = '0;
    int         m_busy = 0;

    always @(posedge Clk) begin
        m_started = 1'b1;
        if (!ResetN) begin
            m_valid = 1'b0; m_busy = 0; m_out = '0; m_over = 1'b0; m_zero = 1'b0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) begin
                m_valid = 1'b1;
                {m_over, m_out} = m_pend;
                m_zero = m_out == 0;
            end
        end else if (InValid && (!m_valid || OutReady)) begin
            if (OP == 4'd10) begin
                m_busy = 8; m_valid = 1'b0; m_pend = ref_alu(OP, InputA, InputB);
            end else begin
                m_valid = 1'b1;
                {m_over, m_out} = ref_alu(OP, InputA, InputB);
                m_zero = m_out == 0;
            end
        end else if (m_valid && OutReady) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (m_started) begin
            chk("model InReady", InReady, m_busy == 0 && (!m_valid || OutReady));
            chk("model OutValid", OutValid, m_valid);
            chk("model Out", Out, m_out);
            chk("model Over", Over, m_over);
            chk("model Zero", Zero, m_zero);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        OP = op; InputA = a; InputB = b; InValid = 1'b1;
        tick();
        InValid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [7:0] o, input logic ov, input logic z);
        chk({name, " OutValid"}, OutValid, 1);
        chk({name, " Out"}, Out, o);
        chk({name, " Over"}, Over, ov);
        chk({name, " Zero"}, Zero, z);
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a, b, o;
        logic       ov, z;
    } vec_t;

    vec_t tbl[16] = '{
        '{4'h1, 8'h81, 8'd1, 8'h02, 1'b1, 1'b0},
        '{4'h2, 8'h81, 8'd1, 8'h40, 1'b1, 1'b0},
        '{4'h1, 8'h81, 8'd9, 8'h00, 1'b0, 1'b1},
        '{4'h1, 8'h81, 8'd8, 8'h00, 1'b1, 1'b1},
        '{4'h2, 8'h81, 8'd8, 8'h00, 1'b1, 1'b1},
        '{4'h2, 8'h81, 8'd0, 8'h81, 1'b0, 1'b0},
        '{4'h5, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1},
        '{4'h6, 8'h03, 8'h80, 8'h01, 1'b0, 1'b0},
        '{4'h6, 8'h80, 8'h03, 8'h00, 1'b0, 1'b1},
        '{4'h9, 8'h81, 8'd9, 8'h03, 1'b0, 1'b0},
        '{4'h3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0},
        '{4'h4, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0},
        '{4'h7, 8'h12, 8'h34, 8'h34, 1'b0, 1'b0},
        '{4'h8, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0},
        '{4'hF, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1},
        '{4'h0, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0}
    };

    initial begin
        tick();
        tick();
        chk("reset OutValid", OutValid, 0);
        chk("reset Out", Out, 0);
        chk("reset Over", Over, 0);
        chk("reset Zero", Zero, 0);
        ResetN = 1'b1;
        tick();
        chk("InReady after reset", InReady, 1);

        issue(4'h0, 8'hF0, 8'h20);
        lit("ADD F0+20", 8'h10, 1'b1, 1'b0);
        tick();

        for (int i = 0; i < 16; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            lit($sformatf("vec%0d", i), tbl[i].o, tbl[i].ov, tbl[i].z);
            tick();
        end

        OP = 4'h0; InputA = 8'h01; InputB = 8'h02; InValid = 1'b1;
        tick();
        lit("b2b ADD", 8'h03, 1'b0, 1'b0);
        OP = 4'h8; InputA = 8'h05; InputB = 8'h07;
        tick();
        lit("b2b SUB", 8'hFE, 1'b1, 1'b0);
        OP = 4'h5; InputA = 8'hFF; InputB = 8'h0F;
        tick();
        lit("b2b XOR", 8'hF0, 1'b0, 1'b0);
        InValid = 1'b0;
        tick();

        issue(4'hA, 8'h12, 8'h0F);
        chk("MUL busy InReady", InReady, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("MUL cycle%0d OutValid", i), OutValid, 0);
            chk($sformatf("MUL cycle%0d InReady", i), InReady, 0);
        end
        tick();
        lit("MUL 12*0F", 8'h0E, 1'b1, 1'b0);
        tick();

        OutReady = 1'b0;
        issue(4'h0, 8'h10, 8'h20);
        lit("hold ADD", 8'h30, 1'b0, 1'b0);
        OP = 4'h5; InputA = 8'hFF; InputB = 8'h0F; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d Out", i), Out, 8'h30);
            chk($sformatf("hold%0d InReady", i), InReady, 0);
        end
        OutReady = 1'b1;
        OP = 4'h8; InputA = 8'h05; InputB = 8'h07;
        tick();
        lit("SUB after hold", 8'hFE, 1'b1, 1'b0);
        InValid = 1'b0;
        tick();

        OutReady = 1'b0;
        issue(4'h0, 8'h01, 8'h01);
        lit("ADD before MUL", 8'h02, 1'b0, 1'b0);
        OutReady = 1'b1;
        issue(4'hA, 8'hFF, 8'hFF);
        chk("FULL->MULT OutValid", OutValid, 0);
        chk("FULL->MULT held Out", Out, 8'h02);
        repeat (8) tick();
        lit("MUL FF*FF", 8'h01, 1'b1, 1'b0);
        tick();

        issue(4'hA, 8'h12, 8'h0F);
        tick();
        tick();
        tick();
        ResetN = 1'b0;
        tick();
        chk("MUL reset OutValid", OutValid, 0);
        chk("MUL reset Out", Out, 0);
        chk("MUL reset InReady", InReady, 1);
        ResetN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("no late result %0d", i), OutValid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
